// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State encodings and framing constants for header and word packing.
package program_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        LOAD,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_W          = 8 * HDR_BYTES;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words.
// word is valid in the cycle word_complete is high (the last byte's transfer).
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned SR_W  = 8 * (BYTES_PER_WORD - 1);

    logic [SR_W-1:0]  shreg;
    logic [CNT_W-1:0] count;

    assign word          = {shreg, data_byte};
    assign word_complete = shift && (count == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
        end else if (shift) begin
            shreg <= {shreg[SR_W-9:0], data_byte};
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header-framed byte stream into program memory writes.
// Holds the core in reset until the whole image has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        reload_i,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        load_done_o,
    output logic        error_o
);

    localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MEMORY_DEPTH);

    state_t           state;
    logic [HDR_W-1:0] word_count;
    logic [IDX_W-1:0] index;
    logic             transfer;
    logic [HDR_W-1:0] hdr_n;
    logic [HDR_W-1:0] last_idx;
    logic [31:0]      word;
    logic             word_complete;

    assign transfer = byte_valid_i && byte_ready_o;
    assign hdr_n    = {word_count[HDR_W-1:8], byte_i};
    assign last_idx = word_count - HDR_W'(1);

    program_loader_word_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (state != LOAD),
        .shift         (transfer && (state == LOAD)),
        .data_byte     (byte_i),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HDR_HI;
            word_count    <= '0;
            index         <= '0;
            byte_ready_o  <= 1'b1;
            mem_write_o   <= 1'b0;
            mem_address_o <= '0;
            mem_data_o    <= '0;
            cpu_reset_o   <= 1'b1;
            load_done_o   <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            mem_write_o <= 1'b0;
            unique case (state)
                HDR_HI: begin
                    if (transfer) begin
                        word_count[HDR_W-1:8] <= byte_i;
                        state                 <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (transfer) begin
                        word_count[7:0] <= byte_i;
                        if (hdr_n == '0 || hdr_n > MAX_N) begin
                            state        <= ERROR;
                            byte_ready_o <= 1'b0;
                            error_o      <= 1'b1;
                        end else begin
                            state <= LOAD;
                            index <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (word_complete) begin
                        mem_write_o   <= 1'b1;
                        mem_address_o <= {{(30-IDX_W){1'b0}}, index, 2'b00};
                        mem_data_o    <= word;
                    end
                    // the strobe cycle retires the word and may close the image
                    if (mem_write_o) begin
                        index <= index + IDX_W'(1);
                        if (HDR_W'(index) == last_idx) begin
                            state        <= DONE;
                            byte_ready_o <= 1'b0;
                            cpu_reset_o  <= 1'b0;
                            load_done_o  <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (reload_i) begin
                        state        <= HDR_HI;
                        byte_ready_o <= 1'b1;
                        cpu_reset_o  <= 1'b1;
                        load_done_o  <= 1'b0;
                        error_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= HDR_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Writes are logged at the falling edge and compared to hand-computed images.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        reload_i;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_reset_o;
    logic        load_done_o;
    logic        error_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    program_loader #(.MEMORY_DEPTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_ready_o  (byte_ready_o),
        .reload_i      (reload_i),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .cpu_reset_o   (cpu_reset_o),
        .load_done_o   (load_done_o),
        .error_o       (error_o)
    );

    always @(negedge clk) begin
        if (mem_write_o) begin
            wa.push_back(mem_address_o);
            wd.push_back(mem_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic put(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_i       = b;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reload();
        reload_i = 1'b1;
        @(posedge clk);
        #1;
        reload_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd1);
        check({tag, "_wr"},    32'(mem_write_o), 32'd0);
        check({tag, "_addr"},  mem_address_o, 32'h0);
        check({tag, "_data"},  mem_data_o, 32'h0);
        check({tag, "_cpurst"}, 32'(cpu_reset_o), 32'd1);
        check({tag, "_done"},  32'(load_done_o), 32'd0);
        check({tag, "_err"},   32'(error_o), 32'd0);
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 32'h0);
            check({tag, "_d0"}, wd[0], 32'h20080005);
            check({tag, "_a1"}, wa[1], 32'h4);
            check({tag, "_d1"}, wd[1], 32'h01095020);
        end
    endtask

    logic [7:0] img [10];
    int         bad;
    logic [31:0] exp_w;

    initial begin
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h01, 8'h09, 8'h50, 8'h20};
        reset        = 1'b1;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        reload_i     = 1'b0;
        idle(2);
        check_reset_vals("rst");
        reset = 1'b0;
        idle(1);

        // back-to-back two-word image
        for (int i = 0; i < 10; i++) put(img[i]);
        check("b2b_strobe2", 32'(mem_write_o), 32'd1);
        check("b2b_cpurst_during", 32'(cpu_reset_o), 32'd1);
        idle(1);
        check("b2b_done", 32'(load_done_o), 32'd1);
        check("b2b_cpurst", 32'(cpu_reset_o), 32'd0);
        check("b2b_ready", 32'(byte_ready_o), 32'd0);
        check_two_words("b2b");
        put(8'hFF);
        idle(2);
        check("b2b_nwr_after", 32'(wa.size()), 32'd2);

        // same image with gaps
        wa.delete(); wd.delete();
        reload();
        check("rl_cpurst", 32'(cpu_reset_o), 32'd1);
        check("rl_done", 32'(load_done_o), 32'd0);
        check("rl_ready", 32'(byte_ready_o), 32'd1);
        check("rl_addr_hold", mem_address_o, 32'h4);
        for (int i = 0; i < 10; i++) begin
            put(img[i]);
            idle(1);
        end
        idle(2);
        check("gap_done", 32'(load_done_o), 32'd1);
        check_two_words("gap");

        // reload with simultaneous byte: byte 0xAA must not become header
        wa.delete(); wd.delete();
        reload_i     = 1'b1;
        byte_valid_i = 1'b1;
        byte_i       = 8'hAA;
        @(posedge clk);
        #1;
        reload_i     = 1'b0;
        byte_valid_i = 1'b0;
        check("rlv_cpurst", 32'(cpu_reset_o), 32'd1);
        check("rlv_ready", 32'(byte_ready_o), 32'd1);
        put(8'h00); put(8'h01);
        check("rlv_noerr", 32'(error_o), 32'd0);
        put(8'h12); put(8'h34); put(8'h56); put(8'h78);
        idle(2);
        check("rlv_done", 32'(load_done_o), 32'd1);
        check("rlv_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("rlv_a0", wa[0], 32'h0);
            check("rlv_d0", wd[0], 32'h12345678);
        end

        // N == 0
        wa.delete(); wd.delete();
        reload();
        put(8'h00); put(8'h00);
        check("n0_err", 32'(error_o), 32'd1);
        check("n0_cpurst", 32'(cpu_reset_o), 32'd1);
        check("n0_ready", 32'(byte_ready_o), 32'd0);
        for (int i = 0; i < 6; i++) put(8'h11);
        check("n0_nwr", 32'(wa.size()), 32'd0);
        check("n0_done", 32'(load_done_o), 32'd0);

        // N == 33
        reload();
        check("n33_errclr", 32'(error_o), 32'd0);
        put(8'h00); put(8'h21);
        check("n33_err", 32'(error_o), 32'd1);

        // N == 256 (high byte only) is also too large
        reload();
        put(8'h01); put(8'h00);
        check("n256_err", 32'(error_o), 32'd1);

        // N == 32 full image
        reload();
        put(8'h00); put(8'h20);
        check("n32_noerr", 32'(error_o), 32'd0);
        for (int w = 0; w < 32; w++)
            for (int j = 0; j < 4; j++) put(8'(4 * w + j));
        idle(2);
        check("n32_done", 32'(load_done_o), 32'd1);
        check("n32_nwr", 32'(wa.size()), 32'd32);
        bad = 0;
        for (int w = 0; w < 32 && w < wa.size(); w++) begin
            exp_w = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            if (wa[w] !== 32'(4 * w) || wd[w] !== exp_w) bad++;
        end
        check("n32_bad_words", 32'(bad), 32'd0);
        check("n32_last_addr", mem_address_o, 32'h7C);
        check("n32_last_data", mem_data_o, 32'h7C7D7E7F);
        check("n32_ready", 32'(byte_ready_o), 32'd0);
        put(8'h55); put(8'h66); put(8'h77); put(8'h88);
        idle(2);
        check("n32_nwr_after", 32'(wa.size()), 32'd32);

        // async reset mid-load, after two bytes of word 1
        wa.delete(); wd.delete();
        reload();
        put(8'h00); put(8'h02);
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        put(8'hCA); put(8'hFE);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        idle(1);
        reset = 1'b0;
        idle(1);
        check("arst_nwr", 32'(wa.size()), 32'd1);
        wa.delete(); wd.delete();
        put(8'h00); put(8'h01);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        idle(2);
        check("arst_done", 32'(load_done_o), 32'd1);
        check("arst_nwr2", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("arst_a0", wa[0], 32'h0);
            check("arst_d0", wd[0], 32'hAABBCCDD);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
